// File: rtl/usb_proxy_pkg.sv
// Shared definitions for the USB token front end: PID values, CRC5 residual,
// token decoder state encoding and frame-number width.
package usb_proxy_pkg;

   localparam int unsigned FRAME_W       = 11;
   localparam logic [7:0]  PID_SOF       = 8'hA5;
   localparam logic [4:0]  CRC5_RESIDUAL = 5'b01100;

   typedef enum logic [2:0] {
      IDLE,
      PID,
      B1,
      B2,
      TAIL,
      DISCARD
   } tok_state_e;

   function automatic logic [FRAME_W-1:0] frame_next(input logic [FRAME_W-1:0] f);
      return f + {{(FRAME_W-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/sof_token_decoder_if.sv
// UTMI/ULPI receive-side byte stream as seen by the token decoders.
interface sof_token_decoder_if;

   logic       rx_active;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       rx_error;

   modport master (output rx_active, output rx_valid, output rx_data, output rx_error);
   modport slave  (input  rx_active, input  rx_valid, input  rx_data, input  rx_error);

endinterface

// File: rtl/usb_crc5.sv
// Combinational USB token CRC5 residual check over 11 data bits then 5 CRC bits,
// all taken LSB-first in wire order.
module usb_crc5
   import usb_proxy_pkg::*;
(
   input  logic [FRAME_W-1:0] data,
   input  logic [4:0]         crc,
   output logic               ok
);

   localparam int unsigned TOK_W = FRAME_W + 5;

   logic [TOK_W-1:0] bits;
   logic [4:0]       lfsr;
   logic             fb;

   always_comb begin
      bits = {crc, data};
      lfsr = 5'h1F;
      fb   = 1'b0;
      for (int unsigned i = 0; i < TOK_W; i++) begin
         fb   = bits[i] ^ lfsr[4];
         lfsr = {lfsr[3:0], 1'b0} ^ ({5{fb}} & 5'b00101);
      end
      ok = (lfsr == CRC5_RESIDUAL);
   end

endmodule

// File: rtl/sof_token_decoder.sv
// SOF token decoder: parses the receive byte stream, validates SOF tokens and
// reports frame number, CRC and sequence errors. Optional macro SOF_INTERVAL_MON_EN
// adds an SOF period monitor driving interval_err.
module sof_token_decoder
   import usb_proxy_pkg::*;
#(
   parameter int unsigned ERR_CNT_W       = 16
`ifdef SOF_INTERVAL_MON_EN
  ,parameter int unsigned INTERVAL_MIN    = 59940,
   parameter int unsigned INTERVAL_MAX    = 60060,
   parameter int unsigned INTERVAL_MIN_HS = 7492,
   parameter int unsigned INTERVAL_MAX_HS = 7508
`endif
)(
   input  logic                 clk,
   input  logic                 rst_n,
   sof_token_decoder_if.slave   rx,
   input  logic                 hs_mode,
   input  logic                 clear_counters,
   output logic                 sof_detected,
   output logic [FRAME_W-1:0]   sof_frame_num,
   output logic                 sof_seen,
   output logic [ERR_CNT_W-1:0] crc_err_count,
   output logic                 seq_err,
   output logic [ERR_CNT_W-1:0] seq_err_count,
   output logic                 interval_err
);

   tok_state_e         state;
   logic [FRAME_W-1:0] frame_q;
   logic [4:0]         crc_q;
   logic               bad_q;
   logic               long_q;
   logic               active_q;
   logic               crc_ok;
   logic               rise;
   logic               sof_ok_ev;
   logic               crc_err_ev;
   logic               seq_bad;

   usb_crc5 u_crc5 (
      .data (frame_q),
      .crc  (crc_q),
      .ok   (crc_ok)
   );

   // End-of-packet verdicts are decided while rx_active is low and the FSM is still busy.
   always_comb begin
      rise       = rx.rx_active & ~active_q;
      sof_ok_ev  = 1'b0;
      crc_err_ev = 1'b0;
      if (!rx.rx_active) begin
         case (state)
            B1, B2:  crc_err_ev = 1'b1;
            TAIL: begin
               if (bad_q || long_q || !crc_ok) crc_err_ev = 1'b1;
               else                            sof_ok_ev  = 1'b1;
            end
            default: ;
         endcase
      end
      seq_bad = sof_seen && (frame_q != frame_next(sof_frame_num))
                && !(hs_mode && (frame_q == sof_frame_num));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         frame_q       <= '0;
         crc_q         <= '0;
         bad_q         <= 1'b0;
         long_q        <= 1'b0;
         active_q      <= 1'b0;
         sof_detected  <= 1'b0;
         sof_frame_num <= '0;
         sof_seen      <= 1'b0;
         crc_err_count <= '0;
         seq_err       <= 1'b0;
         seq_err_count <= '0;
      end else begin
         active_q     <= rx.rx_active;
         sof_detected <= sof_ok_ev;
         seq_err      <= sof_ok_ev && seq_bad;
         if (sof_ok_ev) sof_frame_num <= frame_q;

         if (clear_counters) begin
            crc_err_count <= '0;
            seq_err_count <= '0;
            sof_seen      <= 1'b0;
         end else begin
            if (sof_ok_ev) sof_seen <= 1'b1;
            if (crc_err_ev && (crc_err_count != '1))
               crc_err_count <= crc_err_count + ERR_CNT_W'(1);
            if (sof_ok_ev && seq_bad && (seq_err_count != '1))
               seq_err_count <= seq_err_count + ERR_CNT_W'(1);
         end

         if (rise && (state != IDLE)) begin
            state  <= PID;
            bad_q  <= 1'b0;
            long_q <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (rx.rx_active) begin
                     state  <= PID;
                     bad_q  <= 1'b0;
                     long_q <= 1'b0;
                  end
               end
               PID: begin
                  if (!rx.rx_active)    state <= IDLE;
                  else if (rx.rx_error) state <= DISCARD;
                  else if (rx.rx_valid) state <= (rx.rx_data == PID_SOF) ? B1 : DISCARD;
               end
               B1: begin
                  if (!rx.rx_active) state <= IDLE;
                  else begin
                     if (rx.rx_error) bad_q <= 1'b1;
                     if (rx.rx_valid) begin
                        frame_q[7:0] <= rx.rx_data;
                        state        <= B2;
                     end
                  end
               end
               B2: begin
                  if (!rx.rx_active) state <= IDLE;
                  else begin
                     if (rx.rx_error) bad_q <= 1'b1;
                     if (rx.rx_valid) begin
                        frame_q[10:8] <= rx.rx_data[2:0];
                        crc_q         <= rx.rx_data[7:3];
                        state         <= TAIL;
                     end
                  end
               end
               TAIL: begin
                  if (!rx.rx_active) state <= IDLE;
                  else begin
                     if (rx.rx_error) bad_q  <= 1'b1;
                     if (rx.rx_valid) long_q <= 1'b1;
                  end
               end
               DISCARD: begin
                  if (!rx.rx_active) state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

`ifdef SOF_INTERVAL_MON_EN
   logic [31:0] gap_cnt;
   logic        mon_armed;
   logic        gap_bad;

   always_comb begin
      if (hs_mode) gap_bad = (gap_cnt < INTERVAL_MIN_HS) || (gap_cnt > INTERVAL_MAX_HS);
      else         gap_bad = (gap_cnt < INTERVAL_MIN)    || (gap_cnt > INTERVAL_MAX);
   end

   // Restart at 1 so the value seen at the next SOF equals the edge-to-edge distance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gap_cnt      <= '0;
         mon_armed    <= 1'b0;
         interval_err <= 1'b0;
      end else begin
         interval_err <= sof_ok_ev && mon_armed && gap_bad;
         if (sof_ok_ev)           gap_cnt <= 32'd1;
         else if (gap_cnt != '1)  gap_cnt <= gap_cnt + 32'd1;
         if (clear_counters)      mon_armed <= 1'b0;
         else if (sof_ok_ev)      mon_armed <= 1'b1;
      end
   end
`else
   assign interval_err = 1'b0;
`endif

endmodule

// File: tb/tb_sof_token_decoder.sv
// Directed bench for sof_token_decoder: SOF acceptance, CRC/length rejection,
// sequence checking, counter clear and (with SOF_INTERVAL_MON_EN) the period monitor.
module tb_sof_token_decoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        hs_mode;
   logic        clear_counters;
   logic        sof_detected;
   logic [10:0] sof_frame_num;
   logic        sof_seen;
   logic [15:0] crc_err_count;
   logic        seq_err;
   logic [15:0] seq_err_count;
   logic        interval_err;

   int n_tests = 0;
   int n_fail  = 0;

   logic got_pulse, got_seq, got_int, got_early;
   logic int_ever = 1'b0;

   sof_token_decoder_if rx_if ();

   sof_token_decoder dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .rx             (rx_if),
      .hs_mode        (hs_mode),
      .clear_counters (clear_counters),
      .sof_detected   (sof_detected),
      .sof_frame_num  (sof_frame_num),
      .sof_seen       (sof_seen),
      .crc_err_count  (crc_err_count),
      .seq_err        (seq_err),
      .seq_err_count  (seq_err_count),
      .interval_err   (interval_err)
   );

   always #8 clk = ~clk;

   always @(negedge clk) if (interval_err !== 1'b0) int_ever = 1'b1;

   // Transmitted CRC field: inverted remainder, MSB of the remainder sent first.
   function automatic logic [4:0] crc5_field(input logic [10:0] f);
      logic [4:0] c;
      logic [4:0] r;
      logic       fb;
      c = 5'h1F;
      for (int i = 0; i < 11; i++) begin
         fb = f[i] ^ c[4];
         c  = {c[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
      end
      for (int i = 0; i < 5; i++) r[i] = ~c[4-i];
      return r;
   endfunction

   task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3,
                              input int n, input int err_idx, input logic clr);
      logic [7:0] b [4];
      b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
      @(negedge clk);
      rx_if.rx_active = 1'b1;
      rx_if.rx_valid  = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rx_if.rx_valid = 1'b1;
         rx_if.rx_data  = b[i];
         rx_if.rx_error = (i == err_idx);
      end
      @(negedge clk);
      got_early       = sof_detected;
      rx_if.rx_active = 1'b0;
      rx_if.rx_valid  = 1'b0;
      rx_if.rx_error  = 1'b0;
      clear_counters  = clr;
      @(negedge clk);
      clear_counters = 1'b0;
      got_pulse = sof_detected;
      got_seq   = seq_err;
      got_int   = interval_err;
   endtask

   task automatic send_sof(input logic [10:0] f, input logic flip);
      logic [4:0] c;
      c = crc5_field(f);
      c[0] = c[0] ^ flip;
      send_packet(8'hA5, f[7:0], {c, f[10:8]}, 8'h00, 3, -1, 1'b0);
   endtask

   task automatic do_clear();
      @(negedge clk);
      clear_counters = 1'b1;
      @(negedge clk);
      clear_counters = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_tests++;
      if ({sof_detected, sof_frame_num, sof_seen, crc_err_count, seq_err, seq_err_count, interval_err} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got det=%b fn=%h seen=%b crc=%0d seq=%b seqc=%0d int=%b want all 0",
                  sof_detected, sof_frame_num, sof_seen, crc_err_count, seq_err, seq_err_count, interval_err);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_valid_sof();
      send_sof(11'h123, 1'b0);
      n_tests++;
      if (got_early !== 1'b0) begin n_fail++; $display("FAIL sof_early: got %b want 0", got_early); end
      n_tests++;
      if (got_pulse !== 1'b1) begin n_fail++; $display("FAIL sof_pulse: got %b want 1", got_pulse); end
      n_tests++;
      if (sof_frame_num !== 11'h123) begin n_fail++; $display("FAIL sof_frame: got %h want 123", sof_frame_num); end
      n_tests++;
      if (sof_seen !== 1'b1) begin n_fail++; $display("FAIL sof_seen: got %b want 1", sof_seen); end
      n_tests++;
      if (crc_err_count !== 16'd0 || got_seq !== 1'b0) begin
         n_fail++; $display("FAIL sof_noerr: got crc=%0d seq=%b want 0 0", crc_err_count, got_seq);
      end
      @(negedge clk);
      n_tests++;
      if (sof_detected !== 1'b0) begin n_fail++; $display("FAIL sof_one_cycle: got %b want 0", sof_detected); end
   endtask

   task automatic test_bad_crc();
      send_sof(11'h456, 1'b1);
      n_tests++;
      if (got_pulse !== 1'b0) begin n_fail++; $display("FAIL badcrc_pulse: got %b want 0", got_pulse); end
      n_tests++;
      if (sof_frame_num !== 11'h123) begin n_fail++; $display("FAIL badcrc_frame: got %h want 123", sof_frame_num); end
      n_tests++;
      if (crc_err_count !== 16'd1) begin n_fail++; $display("FAIL badcrc_count: got %0d want 1", crc_err_count); end
   endtask

   task automatic test_clear();
      do_clear();
      n_tests++;
      if (crc_err_count !== 16'd0 || seq_err_count !== 16'd0 || sof_seen !== 1'b0) begin
         n_fail++; $display("FAIL clear_regs: got crc=%0d seqc=%0d seen=%b want 0 0 0", crc_err_count, seq_err_count, sof_seen);
      end
      n_tests++;
      if (sof_frame_num !== 11'h123) begin n_fail++; $display("FAIL clear_frame: got %h want 123", sof_frame_num); end
      // Clear coinciding with a CRC-error increment must win.
      send_packet(8'hA5, 8'h01, 8'h00, 8'h00, 2, -1, 1'b1);
      n_tests++;
      if (crc_err_count !== 16'd0) begin n_fail++; $display("FAIL clear_priority: got %0d want 0", crc_err_count); end
   endtask

   task automatic test_wrap();
      hs_mode = 1'b0;
      do_clear();
      send_sof(11'd2046, 1'b0);
      send_sof(11'd2047, 1'b0);
      n_tests++;
      if (got_seq !== 1'b0) begin n_fail++; $display("FAIL wrap_2047_seq: got %b want 0", got_seq); end
      send_sof(11'd0, 1'b0);
      n_tests++;
      if (got_seq !== 1'b0 || got_pulse !== 1'b1) begin
         n_fail++; $display("FAIL wrap_0: got seq=%b pulse=%b want 0 1", got_seq, got_pulse);
      end
      n_tests++;
      if (sof_frame_num !== 11'd0) begin n_fail++; $display("FAIL wrap_0_frame: got %0d want 0", sof_frame_num); end
      send_sof(11'd5, 1'b0);
      n_tests++;
      if (got_seq !== 1'b1) begin n_fail++; $display("FAIL jump_seq_pulse: got %b want 1", got_seq); end
      n_tests++;
      if (seq_err_count !== 16'd1) begin n_fail++; $display("FAIL jump_seq_count: got %0d want 1", seq_err_count); end
      n_tests++;
      if (sof_frame_num !== 11'd5) begin n_fail++; $display("FAIL jump_frame: got %0d want 5", sof_frame_num); end
      @(negedge clk);
      n_tests++;
      if (seq_err !== 1'b0) begin n_fail++; $display("FAIL seq_one_cycle: got %b want 0", seq_err); end
   endtask

   task automatic test_hs_repeat();
      do_clear();
      hs_mode = 1'b1;
      for (int i = 0; i < 8; i++) send_sof(11'd10, 1'b0);
      send_sof(11'd11, 1'b0);
      n_tests++;
      if (seq_err_count !== 16'd0) begin n_fail++; $display("FAIL hs_repeat: got %0d want 0", seq_err_count); end
      do_clear();
      hs_mode = 1'b0;
      for (int i = 0; i < 8; i++) send_sof(11'd10, 1'b0);
      send_sof(11'd11, 1'b0);
      n_tests++;
      if (seq_err_count !== 16'd7) begin n_fail++; $display("FAIL fs_repeat: got %0d want 7", seq_err_count); end
   endtask

   task automatic test_malformed();
      logic [4:0] c;
      do_clear();
      send_packet(8'h69, 8'h12, 8'h34, 8'h00, 3, -1, 1'b0);
      n_tests++;
      if (got_pulse !== 1'b0 || crc_err_count !== 16'd0) begin
         n_fail++; $display("FAIL other_pid: got pulse=%b crc=%0d want 0 0", got_pulse, crc_err_count);
      end
      c = crc5_field(11'h200);
      send_packet(8'hA5, 8'h00, {c, 3'b010}, 8'h00, 4, -1, 1'b0);
      n_tests++;
      if (got_pulse !== 1'b0 || crc_err_count !== 16'd1) begin
         n_fail++; $display("FAIL overlong: got pulse=%b crc=%0d want 0 1", got_pulse, crc_err_count);
      end
      send_packet(8'hA5, 8'h00, 8'h00, 8'h00, 2, -1, 1'b0);
      n_tests++;
      if (got_pulse !== 1'b0 || crc_err_count !== 16'd2) begin
         n_fail++; $display("FAIL short: got pulse=%b crc=%0d want 0 2", got_pulse, crc_err_count);
      end
      send_packet(8'hA5, 8'h00, {c, 3'b010}, 8'h00, 3, 2, 1'b0);
      n_tests++;
      if (got_pulse !== 1'b0 || crc_err_count !== 16'd3) begin
         n_fail++; $display("FAIL rxerr_sof: got pulse=%b crc=%0d want 0 3", got_pulse, crc_err_count);
      end
      send_packet(8'hA5, 8'h00, {c, 3'b010}, 8'h00, 3, 0, 1'b0);
      n_tests++;
      if (got_pulse !== 1'b0 || crc_err_count !== 16'd3) begin
         n_fail++; $display("FAIL rxerr_pid: got pulse=%b crc=%0d want 0 3", got_pulse, crc_err_count);
      end
      n_tests++;
      if (sof_frame_num !== 11'd11) begin n_fail++; $display("FAIL malformed_frame: got %0d want 11", sof_frame_num); end
   endtask

   task automatic test_interval();
`ifdef SOF_INTERVAL_MON_EN
      hs_mode = 1'b0;
      do_clear();
      send_sof(11'd100, 1'b0);
      n_tests++;
      if (got_int !== 1'b0) begin n_fail++; $display("FAIL interval_first: got %b want 0", got_int); end
      repeat (60000 - 6) @(negedge clk);
      send_sof(11'd101, 1'b0);
      n_tests++;
      if (got_int !== 1'b0 || got_pulse !== 1'b1) begin
         n_fail++; $display("FAIL interval_ok: got int=%b pulse=%b want 0 1", got_int, got_pulse);
      end
      repeat (7000 - 6) @(negedge clk);
      send_sof(11'd102, 1'b0);
      n_tests++;
      if (got_int !== 1'b1) begin n_fail++; $display("FAIL interval_short: got %b want 1", got_int); end
`else
      n_tests++;
      if (int_ever !== 1'b0 || interval_err !== 1'b0) begin
         n_fail++; $display("FAIL interval_off: got seen_high=%b now=%b want 0 0", int_ever, interval_err);
      end
`endif
   endtask

   initial begin
      rx_if.rx_active = 1'b0;
      rx_if.rx_valid  = 1'b0;
      rx_if.rx_data   = 8'h00;
      rx_if.rx_error  = 1'b0;
      hs_mode         = 1'b0;
      clear_counters  = 1'b0;
      test_reset();
      test_valid_sof();
      test_bad_crc();
      test_clear();
      test_wrap();
      test_hs_repeat();
      test_malformed();
      test_interval();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
